// File: rtl/w5300_host_bus_ctrl.sv
// W5300 16-bit direct-address host bus master: runs one timed CS/strobe cycle per
// accepted {rw, addr, data} command and pulses op_done (with read data) on completion.
module w5300_host_bus_ctrl #(
    parameter int SETUP_CYC   = 1,
    parameter int STROBE_CYC  = 4,
    parameter int HOLD_CYC    = 1,
    parameter int RECOVER_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [10:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_ready,
    output logic        op_done,
    output logic [15:0] rd_data,
    output logic        bus_cs_n,
    output logic        bus_wr_n,
    output logic        bus_rd_n,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_doe,
    input  logic [15:0] bus_din
);

    localparam int MAX_A = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int MAX_B = (HOLD_CYC > RECOVER_CYC) ? HOLD_CYC : RECOVER_CYC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD  = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RECOVER
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    logic             cs_n_q, cs_n_d;
    logic             wr_n_q, wr_n_d;
    logic             rd_n_q, rd_n_d;
    logic [9:0]       addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic             doe_q, doe_d;
    logic             done_q, done_d;
    logic [15:0]      rdat_q, rdat_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        cs_n_d  = cs_n_q;
        wr_n_d  = wr_n_q;
        rd_n_d  = rd_n_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        doe_d   = doe_q;
        done_d  = 1'b0;
        rdat_d  = rdat_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    rw_d    = cmd_addr[10];
                    addr_d  = cmd_addr[9:0];
                    cs_n_d  = 1'b0;
                    if (cmd_addr[10]) begin
                        dout_d = cmd_wdata;
                        doe_d  = 1'b1;
                    end
                    cnt_d   = SETUP_LD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    wr_n_d  = ~rw_q;
                    rd_n_d  = rw_q;
                    cnt_d   = STROBE_LD;
                    state_d = S_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    // Read data is captured on the same edge that releases RD_n.
                    if (!rw_q) rdat_d = bus_din;
                    wr_n_d  = 1'b1;
                    rd_n_d  = 1'b1;
                    cnt_d   = HOLD_LD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    cs_n_d  = 1'b1;
                    doe_d   = 1'b0;
                    cnt_d   = RECOVER_LD;
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOVER: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            addr_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            done_q  <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            done_q  <= done_d;
            rdat_q  <= rdat_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign op_done   = done_q;
    assign rd_data   = rdat_q;
    assign bus_cs_n  = cs_n_q;
    assign bus_wr_n  = wr_n_q;
    assign bus_rd_n  = rd_n_q;
    assign bus_addr  = addr_q;
    assign bus_dout  = dout_q;
    assign bus_doe   = doe_q;

endmodule

// File: tb/tb_w5300_host_bus_ctrl.sv
// Bench for w5300_host_bus_ctrl: default-timing instance plus a 2/1/3/1 instance,
// checked cycle by cycle against phase-window arithmetic.
module tb_w5300_host_bus_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        cmd_valid, c2_valid;
    logic [10:0] cmd_addr, c2_addr;
    logic [15:0] cmd_wdata, c2_wdata, bus_din, c2_din;
    logic        cmd_ready, op_done, bus_cs_n, bus_wr_n, bus_rd_n, bus_doe;
    logic [15:0] rd_data, bus_dout;
    logic [9:0]  bus_addr;
    logic        c2_ready, c2_done, c2_cs_n, c2_wr_n, c2_rd_n, c2_doe;
    logic [15:0] c2_rd_data, c2_dout;
    logic [9:0]  c2_baddr;

    w5300_host_bus_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready), .op_done(op_done),
        .rd_data(rd_data), .bus_cs_n(bus_cs_n), .bus_wr_n(bus_wr_n),
        .bus_rd_n(bus_rd_n), .bus_addr(bus_addr), .bus_dout(bus_dout),
        .bus_doe(bus_doe), .bus_din(bus_din)
    );

    w5300_host_bus_ctrl #(.SETUP_CYC(2), .STROBE_CYC(1), .HOLD_CYC(3), .RECOVER_CYC(1)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(c2_valid), .cmd_addr(c2_addr),
        .cmd_wdata(c2_wdata), .cmd_ready(c2_ready), .op_done(c2_done),
        .rd_data(c2_rd_data), .bus_cs_n(c2_cs_n), .bus_wr_n(c2_wr_n),
        .bus_rd_n(c2_rd_n), .bus_addr(c2_baddr), .bus_dout(c2_dout),
        .bus_doe(c2_doe), .bus_din(c2_din)
    );

    typedef struct packed {
        logic        cs_n, wr_n, rd_n, doe;
        logic [9:0]  addr;
        logic [15:0] dout;
        logic        op_done, ready;
        logic [15:0] rd_data;
    } obs_t;

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [15:0] wd;
        logic [15:0] din;
        logic [15:0] exp_rd;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [9:0]  addr_m [2];
    logic [15:0] dout_m [2];
    logic [15:0] rd_m   [2];

    function automatic obs_t get_obs(input bit sel);
        obs_t o;
        if (!sel) o = '{bus_cs_n, bus_wr_n, bus_rd_n, bus_doe, bus_addr, bus_dout, op_done, cmd_ready, rd_data};
        else      o = '{c2_cs_n, c2_wr_n, c2_rd_n, c2_doe, c2_baddr, c2_dout, c2_done, c2_ready, c2_rd_data};
        return o;
    endfunction

    function automatic obs_t idle_obs(input bit sel);
        obs_t e;
        e = '{1'b1, 1'b1, 1'b1, 1'b0, addr_m[sel], dout_m[sel], 1'b0, 1'b1, rd_m[sel]};
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive_din(input bit sel, input logic [15:0] v);
        if (!sel) bus_din = v; else c2_din = v;
    endtask

    // One command on instance sel; every cycle from accept to one past op_done is
    // compared with the expected phase windows. poke raises a foreign command mid-strobe.
    task automatic do_op(input bit sel, input bit wr, input logic [9:0] addr,
                         input logic [15:0] wd, input logic [15:0] din, input bit poke);
        int s, st, h, r, tot, n;
        obs_t e;
        bit stb;
        if (sel) begin s = 2; st = 1; h = 3; r = 1; end
        else     begin s = 1; st = 4; h = 1; r = 2; end
        tot = s + st + h + r;
        n = 0;
        while (!get_obs(sel).ready && n < 40) begin @(posedge clk); #1; n++; end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL ready_timeout sel=%0d got=0 exp=1", sel);
        end
        drive_din(sel, ~din);
        if (!sel) begin cmd_valid = 1'b1; cmd_addr = {wr, addr}; cmd_wdata = wd; end
        else      begin c2_valid  = 1'b1; c2_addr  = {wr, addr}; c2_wdata  = wd; end
        @(posedge clk); #1;
        // scramble cmd_* so any mid-cycle sampling shows up on the bus
        if (!sel) begin cmd_valid = 1'b0; cmd_addr = 11'($urandom); cmd_wdata = ~wd; end
        else      begin c2_valid  = 1'b0; c2_addr  = 11'($urandom); c2_wdata  = ~wd; end
        addr_m[sel] = addr;
        if (wr) dout_m[sel] = wd;
        for (int k = 0; k <= tot + 1; k++) begin
            stb       = (k >= s) && (k < s + st);
            e.cs_n    = !(k < s + st + h);
            e.wr_n    = !(wr && stb);
            e.rd_n    = !(!wr && stb);
            e.doe     = wr && (k < s + st + h);
            e.addr    = addr_m[sel];
            e.dout    = dout_m[sel];
            e.op_done = (k == tot);
            e.ready   = (k >= tot);
            e.rd_data = (!wr && k >= s + st) ? din : rd_m[sel];
            check($sformatf("op sel%0d wr%0d a=%h k=%0d", sel, wr, addr, k), get_obs(sel), e);
            if (k == s + st - 1) drive_din(sel, din);
            if (k == s + st)     drive_din(sel, ~din);
            if (poke && k == s + 1) begin cmd_valid = 1'b1; cmd_addr = {~wr, ~addr}; cmd_wdata = ~wd; end
            if (poke && k == s + 2) cmd_valid = 1'b0;
            @(posedge clk); #1;
        end
        if (!wr) rd_m[sel] = din;
    endtask

    vec_t        vecs [6];
    logic [9:0]  b2b_a [14];
    logic [15:0] b2b_d [14];
    obs_t        o, e;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; bus_din = '0;
        c2_valid  = 1'b0; c2_addr  = '0; c2_wdata  = '0; c2_din  = '0;
        for (int i = 0; i < 2; i++) begin addr_m[i] = '0; dout_m[i] = '0; rd_m[i] = '0; end

        vecs[0] = '{1'b1, 10'h000, 16'h0038, 16'hAAAA, 16'h0000};
        vecs[1] = '{1'b0, 10'h0FE, 16'hBEEF, 16'h5300, 16'h5300};
        vecs[2] = '{1'b1, 10'h3FF, 16'hFFFF, 16'h1234, 16'h5300};
        vecs[3] = '{1'b0, 10'h3FF, 16'h0000, 16'hFFFF, 16'hFFFF};
        vecs[4] = '{1'b0, 10'h000, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 10'h155, 16'h0000, 16'hC3C3, 16'h0000};
        for (int i = 0; i < 14; i++) begin
            b2b_a[i] = 10'(i * 37 + 2);
            b2b_d[i] = 16'(16'h0F01 + i * 16'h1111);
        end

        repeat (3) @(posedge clk);
        #1;
        for (int sel = 0; sel < 2; sel++) begin
            o = get_obs(sel[0]); e = idle_obs(sel[0]);
            o.ready = 1'b0; e.ready = 1'b0;
            check($sformatf("reset_held sel%0d", sel), o, e);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset_release dut", get_obs(1'b0), idle_obs(1'b0));
        check("reset_release dut2", get_obs(1'b1), idle_obs(1'b1));

        // directed table at default timing, incl. the first write and the 5300 read
        for (int i = 0; i < 6; i++) begin
            do_op(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].din, 1'b0);
            check($sformatf("table%0d rd_data", i), rd_data, vecs[i].exp_rd);
        end

        // foreign command raised mid-strobe must be ignored
        do_op(1'b0, 1'b1, 10'h0AA, 16'h5A5A, 16'h0000, 1'b1);
        do_op(1'b0, 1'b0, 10'h0AB, 16'h0000, 16'h7E81, 1'b1);

        // back-to-back config list with cmd_valid held high
        begin
            int idx, cyc, last;
            cmd_valid = 1'b1; cmd_addr = {1'b1, b2b_a[0]}; cmd_wdata = b2b_d[0];
            idx = 0; cyc = 0; last = 0;
            while (idx < 14 && cyc < 14 * 9 + 30) begin
                @(posedge clk); #1;
                cyc++;
                if (!bus_wr_n) begin
                    check($sformatf("b2b%0d addr", idx), bus_addr, b2b_a[idx]);
                    check($sformatf("b2b%0d dout", idx), bus_dout, b2b_d[idx]);
                end
                if (op_done) begin
                    check($sformatf("b2b%0d spacing", idx), cyc - last, 9);
                    last = cyc;
                    idx++;
                    if (idx < 14) begin cmd_addr = {1'b1, b2b_a[idx]}; cmd_wdata = b2b_d[idx]; end
                    else cmd_valid = 1'b0;
                end
            end
            cmd_valid = 1'b0;
            check("b2b count", idx, 14);
            addr_m[0] = b2b_a[13]; dout_m[0] = b2b_d[13];
            @(posedge clk); #1;
            check("b2b idle", get_obs(1'b0), idle_obs(1'b0));
        end

        // alternate timing: 2/1/3/1, op_done 7 edges after accept
        do_op(1'b1, 1'b1, 10'h201, 16'h8001, 16'h0000, 1'b0);
        do_op(1'b1, 1'b0, 10'h0FE, 16'h0000, 16'h5300, 1'b0);

        // randomized traffic on both instances
        for (int i = 0; i < 24; i++)
            do_op(1'b0, 1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) == 0));
        for (int i = 0; i < 8; i++)
            do_op(1'b1, 1'($urandom), 10'($urandom), 16'($urandom), 16'($urandom), 1'b0);

        // reset during the strobe of a write aborts it with no op_done
        cmd_valid = 1'b1; cmd_addr = {1'b1, 10'h123}; cmd_wdata = 16'hCAFE;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort in_strobe wr_n", bus_wr_n, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin addr_m[i] = '0; dout_m[i] = '0; rd_m[i] = '0; end
        o = get_obs(1'b0); e = idle_obs(1'b0);
        o.ready = 1'b0; e.ready = 1'b0;
        check("abort reset_values", o, e);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("abort post k=%0d", k), get_obs(1'b0), idle_obs(1'b0));
        end
        do_op(1'b0, 1'b0, 10'h0FE, 16'h0000, 16'h5300, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
